multicycle_controller: RTL and testbench

Sequencing FSM for the multicycle build of the RV32I core. It steps the shared datapath (PC, instruction and data registers, single ALU, unified memory) through fetch, decode, execute, memory and writeback one state per cycle. It stalls on a memory ready handshake and halts on illegal instructions. It also contains the main and ALU decoders that drive every datapath select and write enable.

---
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM and main/ALU decoders for the multicycle RV32I core.
// Every datapath select and enable is decoded from the current state.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [3:0] alu_control,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_bad_funct;
    logic [1:0] w_imm;
    logic [3:0] w_alu_dec;

    // funct3 encodings that halt the core for R/I-type ops.
    assign w_bad_funct = (funct3 == 3'b011) || ((funct3 == 3'b101) && funct7b5);

    always_comb begin
        w_imm = 2'b00;
        case (op)
            OP_SW:   w_imm = 2'b01;
            OP_BEQ:  w_imm = 2'b10;
            OP_JAL:  w_imm = 2'b11;
            default: w_imm = 2'b00;
        endcase
    end

    always_comb begin
        w_alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  w_alu_dec = ((op == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  w_alu_dec = ALU_AND;
            3'b110:  w_alu_dec = ALU_OR;
            3'b100:  w_alu_dec = ALU_XOR;
            3'b010:  w_alu_dec = ALU_SLT;
            3'b001:  w_alu_dec = ALU_SLL;
            3'b101:  w_alu_dec = ALU_SRL;
            default: w_alu_dec = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_RST;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = (r_state == S_RST) ? 2'b00 : w_imm;
        alu_control = ALU_ADD;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_RST: w_next = S_FETCH;
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = (funct3 == 3'b010) ? S_MEMADR : S_HALT;
                    OP_R:         w_next = w_bad_funct ? S_HALT : S_EXECR;
                    OP_I:         w_next = w_bad_funct ? S_HALT : S_EXECI;
                    OP_BEQ:       w_next = (funct3 == 3'b000) ? S_BEQ : S_HALT;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = w_alu_dec;
                w_next      = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_alu_dec;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = zero;
                instr_done  = 1'b1;
                w_next      = S_FETCH;
            end
            // Jump target was captured in DECODE; ALU recomputes PC+4 for the link.
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                w_next    = S_ALUWB;
            end
            S_HALT: begin
                illegal = 1'b1;
                w_next  = S_HALT;
            end
            default: w_next = S_RST;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the full control word against hand-built values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [3:0] alu_control;
    logic       instr_done, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .alu_control(alu_control), .instr_done(instr_done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, imm_src, alu_control,
                  instr_done, illegal};

    // Field order matches obs above.
    function automatic logic [19:0] ctl(input logic mr, input logic mw, input logic as,
                                        input logic irw, input logic pcw, input logic rw,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] rs, input logic [1:0] im,
                                        input logic [3:0] ac, input logic dn, input logic il);
        return {mr, mw, as, irw, pcw, rw, sa, sb, rs, im, ac, dn, il};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic fetch_ok(input string tag, input logic [1:0] im);
        mem_ready = 1'b1;
        #1;
        check(tag, obs, ctl(1,0,0,1,1,0,2'b00,2'b10,2'b10,im,4'h0,0,0));
        step();
    endtask

    task automatic decode_ok(input string tag, input logic [1:0] im);
        check(tag, obs, ctl(0,0,0,0,0,0,2'b01,2'b01,2'b00,im,4'h0,0,0));
        step();
    endtask

    task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [1:0] sb, input logic [3:0] ac);
        set_instr(o, f3, f7);
        fetch_ok({tag, "_fetch"}, 2'b00);
        decode_ok({tag, "_decode"}, 2'b00);
        check({tag, "_exec"}, obs, ctl(0,0,0,0,0,0,2'b10,sb,2'b00,2'b00,ac,0,0));
        step();
        check({tag, "_aluwb"}, obs, ctl(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,4'h0,1,0));
        step();
    endtask

    task automatic beq_instr(input string tag, input logic z);
        set_instr(7'b1100011, 3'b000, 1'b0);
        zero = z;
        fetch_ok({tag, "_fetch"}, 2'b10);
        decode_ok({tag, "_decode"}, 2'b10);
        check({tag, "_beq"}, obs, ctl(0,0,0,0,z,0,2'b10,2'b00,2'b00,2'b10,4'h1,1,0));
        step();
    endtask

    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_asserted"}, obs, 32'h0);
        step();
        reset = 1'b1;
        #1;
        check({tag, "_rst_state"}, obs, 32'h0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        set_instr(7'b0000000, 3'b000, 1'b0);
        step(); step();
        check("reset_low", obs, 32'h0);
        reset = 1'b1;
        #1;
        check("rst_state", obs, 32'h0);
        step();

        // lw, zero-wait: FETCH DECODE MEMADR MEMREAD MEMWB
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_ok("lw_fetch", 2'b00);
        decode_ok("lw_decode", 2'b00);
        check("lw_memadr", obs, ctl(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,4'h0,0,0));
        step();
        check("lw_memread", obs, ctl(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,4'h0,0,0));
        step();
        check("lw_memwb", obs, ctl(0,0,0,0,0,1,2'b00,2'b00,2'b01,2'b00,4'h0,1,0));
        step();

        // sw with one FETCH stall and two MEMWRITE stall cycles
        set_instr(7'b0100011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("sw_fetch_stall", obs, ctl(1,0,0,0,0,0,2'b00,2'b10,2'b10,2'b01,4'h0,0,0));
        step();
        fetch_ok("sw_fetch", 2'b01);
        decode_ok("sw_decode", 2'b01);
        check("sw_memadr", obs, ctl(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b01,4'h0,0,0));
        step();
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b0;
            #1;
            check("sw_memwrite_wait", obs, ctl(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,4'h0,0,0));
            step();
        end
        mem_ready = 1'b1;
        #1;
        check("sw_memwrite_done", obs, ctl(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,4'h0,1,0));
        step();

        beq_instr("beq_taken", 1'b1);
        beq_instr("beq_not_taken", 1'b0);
        zero = 1'b0;

        alu_instr("r_sub",  7'b0110011, 3'b000, 1'b1, 2'b00, 4'b0001);
        alu_instr("i_addi", 7'b0010011, 3'b000, 1'b1, 2'b01, 4'b0000);
        alu_instr("r_and",  7'b0110011, 3'b111, 1'b0, 2'b00, 4'b0010);
        alu_instr("r_srl",  7'b0110011, 3'b101, 1'b0, 2'b00, 4'b0111);
        alu_instr("i_slt",  7'b0010011, 3'b010, 1'b0, 2'b01, 4'b0101);
        alu_instr("i_slli", 7'b0010011, 3'b001, 1'b0, 2'b01, 4'b0110);
        alu_instr("i_xori", 7'b0010011, 3'b100, 1'b0, 2'b01, 4'b0100);
        alu_instr("r_or",   7'b0110011, 3'b110, 1'b0, 2'b00, 4'b0011);

        // jal: FETCH DECODE JAL ALUWB, imm_src=11 throughout
        set_instr(7'b1101111, 3'b000, 1'b0);
        fetch_ok("jal_fetch", 2'b11);
        decode_ok("jal_decode", 2'b11);
        check("jal_jal", obs, ctl(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b11,4'h0,0,0));
        step();
        check("jal_aluwb", obs, ctl(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,4'h0,1,0));
        step();

        // unknown opcode halts; mem_ready toggles must not matter
        set_instr(7'b0000000, 3'b000, 1'b0);
        fetch_ok("halt_fetch", 2'b00);
        decode_ok("halt_decode", 2'b00);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            #1;
            check("halt_hold", obs, ctl(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,4'h0,0,1));
            step();
        end
        reset_pulse("halt_reset");

        // R-type funct3=011 is unsupported
        set_instr(7'b0110011, 3'b011, 1'b0);
        fetch_ok("sltu_fetch", 2'b00);
        decode_ok("sltu_decode", 2'b00);
        check("sltu_halt", obs, ctl(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,4'h0,0,1));
        step();
        reset_pulse("sltu_reset");

        // reset mid-MEMWRITE drops the access immediately
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_ok("sw2_fetch", 2'b01);
        decode_ok("sw2_decode", 2'b01);
        step();
        mem_ready = 1'b0;
        #1;
        check("sw2_memwrite", obs, ctl(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,4'h0,0,0));
        #2;
        reset_pulse("sw2_reset");
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_ok("resume_fetch", 2'b00);
        decode_ok("resume_decode", 2'b00);
        check("resume_memadr", obs, ctl(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,4'h0,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
